cr_huf_comp_st_short_sched: RTL and testbench
=============================================

Name: cr_huf_comp_st_short_sched

Overview:
- Frame-level scheduler that shares NUM_ST short symbol-table builders between one short-histogram source and one sequence-aligner (SA) reader.
- Grants each new frame to a free builder in round-robin order and records dispatch order.
- Presents builder size/table-ready to the SA strictly in dispatch order, then routes the SA read-done back to the owning builder.
- Sits between the short histogram writer, the cr_huf_comp_st short instances and the SA; includes a per-frame build watchdog.

Parameters:
NUM_ST, 2, number of builders scheduled (legal 2..4).
SEQ_W, 8, frame sequence-id width.
WDOG_W, 16, watchdog counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hw_sched_req  in  1  source requests a builder for a new frame; held until grant
hw_sched_seq_id  in  SEQ_W  sequence id of the requested frame
hw_sched_frame_done  in  1  pulse: last symbol of the granted frame written
sched_hw_gnt  out  1  one-cycle grant pulse
sched_hw_sel  out  $clog2(NUM_ST)  builder owning the current frame; stable while filling
st_not_ready  in  NUM_ST  per-builder not-ready
st_size_rdy  in  NUM_ST  per-builder size ready
st_table_rdy  in  NUM_ST  per-builder table ready
sched_sa_size_rdy  out  1  head builder size ready
sched_sa_table_rdy  out  1  head builder table ready
sched_sa_sel  out  $clog2(NUM_ST)  head builder index
sched_sa_seq_id  out  SEQ_W  head frame sequence id
sa_sched_read_done  in  1  SA has finished reading the head table
sched_st_read_done  out  NUM_ST  read-done routed to the head builder
sw_wdog_limit  in  WDOG_W  build timeout in cycles; 0 disables
sched_wdog_err  out  1  sticky: head frame exceeded limit
sched_proto_err  out  1  sticky: frame_done or read_done with no owner

Behaviour:
- The clock and reset are clk and rst. Reset is synchronous and active-high. All state is registered.
- Reset values: every output is 0; every builder is IDLE; the order queue is empty; rr_ptr = 0; errors are cleared. Reset mid-frame abandons all frames immediately.
- Per-builder state machine: IDLE -> FILL on grant; FILL -> BUILD on hw_sched_frame_done; BUILD -> READ when the builder is head and st_table_rdy is high; READ -> IDLE on sa_sched_read_done.
- Builder eligibility: a builder is eligible when it is IDLE, its st_not_ready is low, and no builder is in FILL. Only one frame fills at a time.
- Grant timing: grant decision registered, 1 cycle after hw_sched_req with an eligible builder present. Search starts at rr_ptr and picks the first eligible builder. On grant, rr_ptr = winner + 1 mod NUM_ST, and {winner, seq_id} is pushed into the order queue. The source drops its request the cycle after sched_hw_gnt.
- Order queue: depth NUM_ST, cannot overflow (at most one entry per builder). Because a push requires an IDLE builder, the queue is never full at a push.
- SA outputs: sched_sa_size_rdy = st_size_rdy[head] & queue non-empty; sched_sa_table_rdy = st_table_rdy[head] & queue non-empty. Both are combinational from registered head state. Readiness from non-head builders is masked.
- Read-done routing: sched_st_read_done[head] = sa_sched_read_done, combinational and same cycle. The head pops on that cycle and the builder returns to IDLE, becoming eligible the next cycle.
- Simultaneous grant and pop: both proceed in the same cycle. The queue count stays unchanged, and a wrap-around pointer handles the push/pop.
- hw_sched_frame_done with no builder in FILL, or sa_sched_read_done with an empty queue: input ignored, sched_proto_err set.
- Watchdog: counts cycles while the head is in FILL or BUILD; resets on pop. When the count equals a non-zero sw_wdog_limit, sched_wdog_err sets. The counter saturates. The frame is not aborted.
- sched_hw_sel holds the FILL builder index; it holds its last value while no builder is in FILL.

Decomposition:
- Shared package cr_huf_compPKG gets:
  - builder state enum: IDLE, FILL, BUILD, READ;
  - order-queue entry struct {idx, seq_id};
  - CR_HUF_COMP_SCHED_NUM_ST default constant.
- One sub-module: cr_huf_comp_st_sched_ordq, a small circular FIFO with push/pop/head/count.
- Round-robin select stays inline.

Test Plan:
- Single frame: req with seq 0x05 -> gnt after 1 cycle, sel=0. Then frame_done, then st_table_rdy[0] -> sched_sa_table_rdy=1, sa_seq_id=0x05. read_done -> sched_st_read_done=2'b01 same cycle.
- Ping-pong: frames 0x10, 0x11 back-to-back -> sel 0 then 1. Builder 1 table_rdy first -> SA outputs stay 0 until builder 0 is ready; order presented is 0x10, 0x11.
- Busy stall: both builders in BUILD with a new request -> no gnt. read_done on head -> gnt the following cycle to the freed builder.
- not_ready mask: st_not_ready=2'b01 and rr_ptr=0 -> gnt sel=1.
- Watchdog: limit=20, table_rdy withheld -> sched_wdog_err rises on cycle 20 after head push and stays set after pop. limit=0 -> never sets.
- Protocol/reset: read_done with empty queue -> sched_proto_err=1, no pulse on sched_st_read_done. rst asserted mid-FILL -> all outputs 0 the next cycle, and a new req is granted sel=0.

Source files
------------

// File: rtl/cr_huf_compPKG.sv
// Shared definitions for the short symbol-table scheduler slice.
// Contents: builder state enum, order-queue entry struct, default builder
// count, maximum field widths carried by a queue entry, and a small
// modulo-increment helper used for round-robin and ring pointers.
package cr_huf_compPKG;

  localparam int CR_HUF_COMP_SCHED_NUM_ST    = 2;
  // Queue entries are sized for the largest legal configuration (4 builders,
  // 16-bit sequence ids); narrower instances zero-extend on push.
  localparam int CR_HUF_COMP_SCHED_IDX_W_MAX = 2;
  localparam int CR_HUF_COMP_SCHED_SEQ_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BUILD = 2'd2,
    READ  = 2'd3
  } st_state_e;

  typedef struct packed {
    logic [CR_HUF_COMP_SCHED_IDX_W_MAX-1:0] idx;
    logic [CR_HUF_COMP_SCHED_SEQ_W_MAX-1:0] seq_id;
  } ordq_entry_t;

  // (v + 1) mod n for v < n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/cr_huf_comp_st_short_sched_if.sv
// Bundle of all scheduler handshakes: histogram source (req/gnt/sel/frame_done),
// per-builder status and read-done, SA head presentation, watchdog limit and
// sticky error flags.
// master: the scheduler side.  slave: the surrounding environment.
interface cr_huf_comp_st_short_sched_if #(
  parameter int NUM_ST = cr_huf_compPKG::CR_HUF_COMP_SCHED_NUM_ST,
  parameter int SEQ_W  = 8,
  parameter int WDOG_W = 16
);
  localparam int IDX_W = $clog2(NUM_ST);

  logic              hw_sched_req;
  logic [SEQ_W-1:0]  hw_sched_seq_id;
  logic              hw_sched_frame_done;
  logic              sched_hw_gnt;
  logic [IDX_W-1:0]  sched_hw_sel;
  logic [NUM_ST-1:0] st_not_ready;
  logic [NUM_ST-1:0] st_size_rdy;
  logic [NUM_ST-1:0] st_table_rdy;
  logic              sched_sa_size_rdy;
  logic              sched_sa_table_rdy;
  logic [IDX_W-1:0]  sched_sa_sel;
  logic [SEQ_W-1:0]  sched_sa_seq_id;
  logic              sa_sched_read_done;
  logic [NUM_ST-1:0] sched_st_read_done;
  logic [WDOG_W-1:0] sw_wdog_limit;
  logic              sched_wdog_err;
  logic              sched_proto_err;

  modport master (
    input  hw_sched_req, hw_sched_seq_id, hw_sched_frame_done,
    input  st_not_ready, st_size_rdy, st_table_rdy,
    input  sa_sched_read_done, sw_wdog_limit,
    output sched_hw_gnt, sched_hw_sel,
    output sched_sa_size_rdy, sched_sa_table_rdy, sched_sa_sel, sched_sa_seq_id,
    output sched_st_read_done, sched_wdog_err, sched_proto_err
  );

  modport slave (
    output hw_sched_req, hw_sched_seq_id, hw_sched_frame_done,
    output st_not_ready, st_size_rdy, st_table_rdy,
    output sa_sched_read_done, sw_wdog_limit,
    input  sched_hw_gnt, sched_hw_sel,
    input  sched_sa_size_rdy, sched_sa_table_rdy, sched_sa_sel, sched_sa_seq_id,
    input  sched_st_read_done, sched_wdog_err, sched_proto_err
  );

endinterface

// File: rtl/cr_huf_comp_st_sched_ordq.sv
// Dispatch-order queue: small circular FIFO of {builder idx, seq id}.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head (entry at
// read pointer), count (occupancy). Push and pop may coincide; a pop on an
// empty queue or a push into a full queue without a pop is dropped.
module cr_huf_comp_st_sched_ordq
  import cr_huf_compPKG::*;
#(
  parameter int DEPTH = CR_HUF_COMP_SCHED_NUM_ST
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  ordq_entry_t                  push_data,
  input  logic                         pop,
  output ordq_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  ordq_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});
  assign push_ok_s = push & ((count_r != CNT_W'(DEPTH)) | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Ring storage, wrap-around pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{idx: 2'b00, seq_id: 16'h0000};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= PTR_W'(wrap_inc(32'(wr_ptr_r), DEPTH));
      end
      if (pop_ok_s) begin
        rd_ptr_r <= PTR_W'(wrap_inc(32'(rd_ptr_r), DEPTH));
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cr_huf_comp_st_short_sched.sv
// Frame scheduler sharing NUM_ST short symbol-table builders between the
// short-histogram source and the sequence aligner (SA).
// Ports: clk, rst (sync, active-high), bus (master side of
// cr_huf_comp_st_short_sched_if): source req/seq_id/frame_done -> gnt/sel;
// builder not_ready/size_rdy/table_rdy -> SA head size/table ready, sel,
// seq_id; SA read_done -> per-builder read_done; watchdog limit -> errors.
module cr_huf_comp_st_short_sched
  import cr_huf_compPKG::*;
#(
  parameter int NUM_ST = CR_HUF_COMP_SCHED_NUM_ST,
  parameter int SEQ_W  = 8,
  parameter int WDOG_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  cr_huf_comp_st_short_sched_if.master  bus
);
  localparam int IDX_W = $clog2(NUM_ST);
  localparam int CNT_W = $clog2(NUM_ST+1);

  st_state_e         state_r     [NUM_ST];
  st_state_e         state_nxt_s [NUM_ST];
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  sel_r;
  logic              gnt_r;
  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              wdog_err_r;
  logic              proto_err_r;

  logic [NUM_ST-1:0] elig_s;
  logic              fill_any_s;
  logic              found_s;
  logic [IDX_W-1:0]  cand_s;
  logic [IDX_W-1:0]  winner_s;
  logic              gnt_take_s;
  ordq_entry_t       push_entry_s;
  ordq_entry_t       head_s;
  logic [CNT_W-1:0]  q_count_s;
  logic              q_empty_s;
  logic [IDX_W-1:0]  head_idx_s;
  logic              pop_s;
  logic              head_active_s;
  logic [WDOG_W-1:0] wdog_inc_s;

  // Eligibility: idle, ready, and no other frame currently filling; then
  // round-robin search starting at rr_ptr for the first eligible builder.
  always_comb begin
    fill_any_s = 1'b0;
    elig_s     = {NUM_ST{1'b0}};
    found_s    = 1'b0;
    winner_s   = {IDX_W{1'b0}};
    cand_s     = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_ST; i++) begin
      fill_any_s = fill_any_s | (state_r[i] == FILL);
    end
    for (int i = 0; i < NUM_ST; i++) begin
      elig_s[i] = (state_r[i] == IDLE) & ~bus.st_not_ready[i] & ~fill_any_s;
    end
    for (int k = 0; k < NUM_ST; k++) begin
      cand_s = IDX_W'((int'(rr_ptr_r) + k) % NUM_ST);
      if (!found_s && elig_s[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  assign gnt_take_s          = bus.hw_sched_req & found_s;
  assign push_entry_s.idx    = CR_HUF_COMP_SCHED_IDX_W_MAX'(winner_s);
  assign push_entry_s.seq_id = CR_HUF_COMP_SCHED_SEQ_W_MAX'(bus.hw_sched_seq_id);
  assign q_empty_s           = (q_count_s == {CNT_W{1'b0}});
  assign head_idx_s          = IDX_W'(head_s.idx);
  // A read-done with nothing queued has no owner and is dropped.
  assign pop_s               = bus.sa_sched_read_done & ~q_empty_s;

  cr_huf_comp_st_sched_ordq #(.DEPTH(NUM_ST)) u_ordq (
    .clk       (clk),
    .rst       (rst),
    .push      (gnt_take_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (q_count_s)
  );

  // Per-builder next state; a pop returns the head builder to IDLE from any state.
  always_comb begin
    for (int i = 0; i < NUM_ST; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        IDLE: begin
          if (gnt_take_s && (winner_s == IDX_W'(i))) state_nxt_s[i] = FILL;
          else                                      state_nxt_s[i] = IDLE;
        end
        FILL: begin
          if (bus.hw_sched_frame_done) state_nxt_s[i] = BUILD;
          else                         state_nxt_s[i] = FILL;
        end
        BUILD: begin
          if (!q_empty_s && (head_idx_s == IDX_W'(i)) && bus.st_table_rdy[i]) state_nxt_s[i] = READ;
          else                                                               state_nxt_s[i] = BUILD;
        end
        READ:    state_nxt_s[i] = READ;
        default: state_nxt_s[i] = IDLE;
      endcase
      if (pop_s && (head_idx_s == IDX_W'(i))) state_nxt_s[i] = IDLE;
      else                                    state_nxt_s[i] = state_nxt_s[i];
    end
  end

  // Builder state, grant pulse, fill owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ST; i++) state_r[i] <= IDLE;
      rr_ptr_r <= {IDX_W{1'b0}};
      sel_r    <= {IDX_W{1'b0}};
      gnt_r    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ST; i++) state_r[i] <= state_nxt_s[i];
      gnt_r <= gnt_take_s;
      if (gnt_take_s) begin
        sel_r    <= winner_s;
        rr_ptr_r <= IDX_W'(wrap_inc(32'(winner_s), NUM_ST));
      end
    end
  end

  assign head_active_s = ~q_empty_s & ((state_r[head_idx_s] == FILL) | (state_r[head_idx_s] == BUILD));
  assign wdog_inc_s    = (wdog_cnt_r == {WDOG_W{1'b1}}) ? wdog_cnt_r : (wdog_cnt_r + WDOG_W'(1'b1));

  // Head-frame build watchdog (saturating) and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_r  <= {WDOG_W{1'b0}};
      wdog_err_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (pop_s)              wdog_cnt_r <= {WDOG_W{1'b0}};
      else if (head_active_s) wdog_cnt_r <= wdog_inc_s;
      if (head_active_s && !pop_s && (bus.sw_wdog_limit != {WDOG_W{1'b0}}) &&
          (wdog_inc_s == bus.sw_wdog_limit)) begin
        wdog_err_r <= 1'b1;
      end
      if ((bus.hw_sched_frame_done && !fill_any_s) || (bus.sa_sched_read_done && q_empty_s)) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign bus.sched_hw_gnt       = gnt_r;
  assign bus.sched_hw_sel       = sel_r;
  assign bus.sched_sa_size_rdy  = ~q_empty_s & bus.st_size_rdy[head_idx_s];
  assign bus.sched_sa_table_rdy = ~q_empty_s & bus.st_table_rdy[head_idx_s];
  assign bus.sched_sa_sel       = q_empty_s ? {IDX_W{1'b0}} : head_idx_s;
  assign bus.sched_sa_seq_id    = q_empty_s ? {SEQ_W{1'b0}} : SEQ_W'(head_s.seq_id);
  assign bus.sched_st_read_done = pop_s ? (NUM_ST'(1'b1) << head_idx_s) : {NUM_ST{1'b0}};
  assign bus.sched_wdog_err     = wdog_err_r;
  assign bus.sched_proto_err    = proto_err_r;

endmodule

// File: tb/tb_cr_huf_comp_st_short_sched.sv
// Directed bench for cr_huf_comp_st_short_sched with NUM_ST=2.
module tb_cr_huf_comp_st_short_sched;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cr_huf_comp_st_short_sched_if #(.NUM_ST(2), .SEQ_W(8), .WDOG_W(16)) bus ();

  cr_huf_comp_st_short_sched #(.NUM_ST(2), .SEQ_W(8), .WDOG_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.hw_sched_req        = 1'b0;
    bus.hw_sched_seq_id     = 8'h00;
    bus.hw_sched_frame_done = 1'b0;
    bus.st_not_ready        = 2'b00;
    bus.st_size_rdy         = 2'b00;
    bus.st_table_rdy        = 2'b00;
    bus.sa_sched_read_done  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},    32'(bus.sched_hw_gnt),       32'h0);
    chk({tag, "_sel"},    32'(bus.sched_hw_sel),       32'h0);
    chk({tag, "_size"},   32'(bus.sched_sa_size_rdy),  32'h0);
    chk({tag, "_table"},  32'(bus.sched_sa_table_rdy), 32'h0);
    chk({tag, "_sasel"},  32'(bus.sched_sa_sel),       32'h0);
    chk({tag, "_seq"},    32'(bus.sched_sa_seq_id),    32'h0);
    chk({tag, "_rdone"},  32'(bus.sched_st_read_done), 32'h0);
    chk({tag, "_wdog"},   32'(bus.sched_wdog_err),     32'h0);
    chk({tag, "_proto"},  32'(bus.sched_proto_err),    32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    bus.sw_wdog_limit = 16'd0;
    step();
    step();
    settle();
    chk_zero("reset");
    rst = 1'b0;

    // Single frame through all builder states.
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h05; settle();
    chk("t1_gnt_latency", 32'(bus.sched_hw_gnt), 32'h0);
    step(); settle();
    chk("t1_gnt", 32'(bus.sched_hw_gnt), 32'h1);
    chk("t1_sel", 32'(bus.sched_hw_sel), 32'h0);
    chk("t1_seq_fill", 32'(bus.sched_sa_seq_id), 32'h05);
    chk("t1_table_fill", 32'(bus.sched_sa_table_rdy), 32'h0);
    step(); settle();
    chk("t1_no_regrant", 32'(bus.sched_hw_gnt), 32'h0);
    bus.hw_sched_req = 1'b0; bus.hw_sched_frame_done = 1'b1;
    step();
    bus.hw_sched_frame_done = 1'b0;
    bus.st_table_rdy = 2'b01; bus.st_size_rdy = 2'b01; settle();
    chk("t1_table_rdy", 32'(bus.sched_sa_table_rdy), 32'h1);
    chk("t1_size_rdy", 32'(bus.sched_sa_size_rdy), 32'h1);
    chk("t1_seq", 32'(bus.sched_sa_seq_id), 32'h05);
    step();
    bus.sa_sched_read_done = 1'b1; settle();
    chk("t1_read_done", 32'(bus.sched_st_read_done), 32'h1);
    step();
    bus.sa_sched_read_done = 1'b0; bus.st_table_rdy = 2'b00; bus.st_size_rdy = 2'b00; settle();
    chk("t1_empty_table", 32'(bus.sched_sa_table_rdy), 32'h0);
    chk("t1_empty_seq", 32'(bus.sched_sa_seq_id), 32'h0);
    chk("t1_proto_clean", 32'(bus.sched_proto_err), 32'h0);

    // Ping-pong: two frames, builder 1 ready first must not overtake.
    do_reset();
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h10;
    step(); settle();
    chk("pp_gnt0", 32'(bus.sched_hw_gnt), 32'h1);
    chk("pp_sel0", 32'(bus.sched_hw_sel), 32'h0);
    bus.hw_sched_seq_id = 8'h11; bus.hw_sched_frame_done = 1'b1;
    step();
    bus.hw_sched_frame_done = 1'b0; settle();
    chk("pp_gap", 32'(bus.sched_hw_gnt), 32'h0);
    step(); settle();
    chk("pp_gnt1", 32'(bus.sched_hw_gnt), 32'h1);
    chk("pp_sel1", 32'(bus.sched_hw_sel), 32'h1);
    bus.hw_sched_req = 1'b0; bus.hw_sched_frame_done = 1'b1;
    step();
    bus.hw_sched_frame_done = 1'b0;
    bus.st_table_rdy = 2'b10; settle();
    chk("pp_mask_table", 32'(bus.sched_sa_table_rdy), 32'h0);
    chk("pp_head_sel", 32'(bus.sched_sa_sel), 32'h0);
    chk("pp_head_seq", 32'(bus.sched_sa_seq_id), 32'h10);
    step(); settle();
    chk("pp_mask_hold", 32'(bus.sched_sa_table_rdy), 32'h0);

    // Busy stall: both builders in BUILD, new request waits.
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h20;
    step(); settle();
    chk("stall_a", 32'(bus.sched_hw_gnt), 32'h0);
    step(); settle();
    chk("stall_b", 32'(bus.sched_hw_gnt), 32'h0);
    bus.st_table_rdy = 2'b11; settle();
    chk("pp_first_table", 32'(bus.sched_sa_table_rdy), 32'h1);
    chk("pp_first_seq", 32'(bus.sched_sa_seq_id), 32'h10);
    step();
    bus.sa_sched_read_done = 1'b1; settle();
    chk("pp_rdone0", 32'(bus.sched_st_read_done), 32'h1);
    step();
    bus.sa_sched_read_done = 1'b0; settle();
    chk("stall_release_lat", 32'(bus.sched_hw_gnt), 32'h0);
    chk("pp_second_seq", 32'(bus.sched_sa_seq_id), 32'h11);
    chk("pp_second_sel", 32'(bus.sched_sa_sel), 32'h1);
    chk("pp_second_table", 32'(bus.sched_sa_table_rdy), 32'h1);
    step(); settle();
    chk("stall_gnt", 32'(bus.sched_hw_gnt), 32'h1);
    chk("stall_sel", 32'(bus.sched_hw_sel), 32'h0);
    bus.hw_sched_req = 1'b0; bus.st_table_rdy = 2'b00;
    bus.sa_sched_read_done = 1'b1; settle();
    chk("pp_rdone1", 32'(bus.sched_st_read_done), 32'h2);
    step();
    bus.sa_sched_read_done = 1'b0; settle();
    chk("stall_head_seq", 32'(bus.sched_sa_seq_id), 32'h20);
    chk("stall_head_table", 32'(bus.sched_sa_table_rdy), 32'h0);

    // Grant and pop in the same cycle.
    bus.hw_sched_frame_done = 1'b1;
    step();
    bus.hw_sched_frame_done = 1'b0; bus.st_table_rdy = 2'b01;
    step();
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h30; bus.sa_sched_read_done = 1'b1; settle();
    chk("sim_rdone", 32'(bus.sched_st_read_done), 32'h1);
    step();
    bus.sa_sched_read_done = 1'b0; settle();
    chk("sim_gnt", 32'(bus.sched_hw_gnt), 32'h1);
    chk("sim_sel", 32'(bus.sched_hw_sel), 32'h1);
    chk("sim_head_seq", 32'(bus.sched_sa_seq_id), 32'h30);
    chk("sim_head_sel", 32'(bus.sched_sa_sel), 32'h1);
    bus.hw_sched_req = 1'b0; bus.st_table_rdy = 2'b00;

    // not_ready mask skips builder 0.
    do_reset();
    bus.st_not_ready = 2'b01; bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h40;
    step(); settle();
    chk("nr_gnt", 32'(bus.sched_hw_gnt), 32'h1);
    chk("nr_sel", 32'(bus.sched_hw_sel), 32'h1);
    bus.hw_sched_req = 1'b0; bus.st_not_ready = 2'b00; settle();
    chk("nr_seq", 32'(bus.sched_sa_seq_id), 32'h40);

    // Reset mid-FILL abandons the frame.
    rst = 1'b1;
    step(); settle();
    chk_zero("rst_mid");
    rst = 1'b0;
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h41;
    step(); settle();
    chk("rst_regnt", 32'(bus.sched_hw_gnt), 32'h1);
    chk("rst_resel", 32'(bus.sched_hw_sel), 32'h0);
    bus.hw_sched_req = 1'b0;

    // Read-done with an empty queue.
    do_reset();
    bus.sa_sched_read_done = 1'b1; settle();
    chk("proto_no_pulse", 32'(bus.sched_st_read_done), 32'h0);
    step();
    bus.sa_sched_read_done = 1'b0; settle();
    chk("proto_set", 32'(bus.sched_proto_err), 32'h1);
    step(); settle();
    chk("proto_sticky", 32'(bus.sched_proto_err), 32'h1);

    // Watchdog with limit 20.
    do_reset();
    settle();
    chk("proto_cleared", 32'(bus.sched_proto_err), 32'h0);
    bus.sw_wdog_limit = 16'd20;
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h50;
    step();
    bus.hw_sched_req = 1'b0; settle();
    chk("wd_gnt", 32'(bus.sched_hw_gnt), 32'h1);
    chk("wd_start", 32'(bus.sched_wdog_err), 32'h0);
    for (int i = 1; i < 20; i++) begin
      step(); settle();
      chk($sformatf("wd_quiet_%0d", i), 32'(bus.sched_wdog_err), 32'h0);
    end
    step(); settle();
    chk("wd_rise", 32'(bus.sched_wdog_err), 32'h1);
    bus.hw_sched_frame_done = 1'b1;
    step();
    bus.hw_sched_frame_done = 1'b0; bus.st_table_rdy = 2'b01;
    step();
    bus.sa_sched_read_done = 1'b1;
    step();
    bus.sa_sched_read_done = 1'b0; bus.st_table_rdy = 2'b00; settle();
    chk("wd_sticky", 32'(bus.sched_wdog_err), 32'h1);
    chk("wd_popped", 32'(bus.sched_sa_table_rdy), 32'h0);

    // Watchdog disabled with limit 0.
    do_reset();
    settle();
    chk("wd_cleared", 32'(bus.sched_wdog_err), 32'h0);
    bus.sw_wdog_limit = 16'd0;
    bus.hw_sched_req = 1'b1; bus.hw_sched_seq_id = 8'h51;
    step();
    bus.hw_sched_req = 1'b0;
    repeat (40) step();
    settle();
    chk("wd_disabled", 32'(bus.sched_wdog_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
